mips_regfile_mp: RTL and testbench

MIPS_REGFILE_MP -- requirements
Module: mips_regfile_mp

---
 rtl/mips_regfile_pkg.sv | 15 +
 rtl/mips_regfile_scoreboard.sv | 51 +++++
 rtl/mips_regfile_mp.sv | 95 +++++++++
 tb/tb_mips_regfile_mp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_regfile_pkg.sv
// Shared types and fixed register numbers for the MIPS register file.
package mips_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REGS   = 32;
    localparam int DEF_IDX_W  = $clog2(DEF_REGS);

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_IDX_W-1:0]  reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_V0   = 5'd2;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// write commit; an issue in the same cycle as a write to that index wins.
module mips_regfile_scoreboard
    import mips_regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_valid,
    input  logic [IDX_W-1:0]    iss_idx,
    input  logic                we0,
    input  logic [IDX_W-1:0]    wa0,
    input  logic                we1,
    input  logic [IDX_W-1:0]    wa1,
    output logic [NUM_REGS-1:0] pending,
    output logic [IDX_W:0]      pend_count
);

    logic [NUM_REGS-1:0] pend_nxt;

    // Next pending vector; entry 0 never becomes pending, and indices past
    // NUM_REGS match no entry so they are ignored naturally.
    always_comb begin
        pend_nxt    = pending;
        pend_nxt[0] = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (iss_valid && iss_idx == IDX_W'(i)) begin
                pend_nxt[i] = 1'b1;
            end else if ((we0 && wa0 == IDX_W'(i)) || (we1 && wa1 == IDX_W'(i))) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    // Pending state register; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= pend_nxt;
    end

    // Population count of the registered pending bits.
    always_comb begin
        pend_count = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            pend_count = pend_count + (IDX_W+1)'(pending[i]);
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-read-port MIPS register file with two write ports, a pending-write
// scoreboard and a debug read port.
// Optional feature: define MIPS_REGFILE_BYPASS_EN to forward same-cycle
// write data (and clear the busy flag) on the read ports.
module mips_regfile_mp
    import mips_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_RD-1:0][IDX_W-1:0]     rd_idx,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             we0,
    input  logic [IDX_W-1:0]                 wa0,
    input  logic [DATA_WIDTH-1:0]            wd0,
    input  logic                             we1,
    input  logic [IDX_W-1:0]                 wa1,
    input  logic [DATA_WIDTH-1:0]            wd1,
    input  logic                             iss_valid,
    input  logic [IDX_W-1:0]                 iss_idx,
    output logic [IDX_W:0]                   pend_count,
    input  logic [IDX_W-1:0]                 dbg_idx,
    output logic [DATA_WIDTH-1:0]            dbg_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;

    // A usable index is nonzero and inside the implemented register range.
    function automatic logic idx_live(input logic [IDX_W-1:0] idx);
        return (idx != IDX_W'(REG_ZERO)) && ({1'b0, idx} < (IDX_W+1)'(NUM_REGS));
    endfunction

    // Data array update; port 1 takes priority on a shared index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (we1 && wa1 == IDX_W'(i))      regs[i] <= wd1;
                else if (we0 && wa0 == IDX_W'(i)) regs[i] <= wd0;
            end
        end
    end

    mips_regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .iss_valid  (iss_valid),
        .iss_idx    (iss_idx),
        .we0        (we0),
        .wa0        (wa0),
        .we1        (we1),
        .wa1        (wa1),
        .pending    (pending),
        .pend_count (pend_count)
    );

    // Per-port combinational read mux.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0]      idx;
        logic                  live;
        logic [DATA_WIDTH-1:0] stored;

        assign idx    = rd_idx[p];
        assign live   = idx_live(idx);
        assign stored = live ? regs[idx] : '0;

`ifdef MIPS_REGFILE_BYPASS_EN
        logic hit0, hit1, iss_hit;

        assign hit0    = live && we0 && (wa0 == idx);
        assign hit1    = live && we1 && (wa1 == idx);
        assign iss_hit = iss_valid && (iss_idx == idx);

        assign rd_data[p] = hit1 ? wd1 : (hit0 ? wd0 : stored);
        // A forwarded write resolves the pending result unless it is re-issued now.
        assign rd_busy[p] = live && pending[idx] && !((hit0 || hit1) && !iss_hit);
`else
        assign rd_data[p] = stored;
        assign rd_busy[p] = live && pending[idx];
`endif
    end

    assign dbg_data = idx_live(dbg_idx) ? regs[dbg_idx] : '0;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Self-checking bench for mips_regfile_mp against a plain array/bit model.
module tb_mips_regfile_mp;
    import mips_regfile_pkg::*;

    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0][4:0]  rd_idx;
    logic [NR-1:0][31:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             we0, we1, iss_valid;
    logic [4:0]       wa0, wa1, iss_idx, dbg_idx;
    logic [31:0]      wd0, wd1, dbg_data;
    logic [5:0]       pend_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem  [32];
    bit          pend [32];

    mips_regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD(NR)) dut (
        .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_idx(iss_idx), .pend_count(pend_count),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef MIPS_REGFILE_BYPASS_EN
        if (we1 && wa1 == idx) return wd1;
        if (we0 && wa0 == idx) return wd0;
`endif
        return mem[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
`ifdef MIPS_REGFILE_BYPASS_EN
        if (((we0 && wa0 == idx) || (we1 && wa1 == idx)) && !(iss_valid && iss_idx == idx))
            return 1'b0;
`endif
        return pend[idx];
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(pend[i]);
        return c;
    endfunction

    task automatic idle();
        reset = 0; we0 = 0; we1 = 0; iss_valid = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_idx = 0;
    endtask

    // One rising edge; the model takes the same inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
        end else begin
            if (we0 && wa0 != 0) begin mem[wa0] = wd0; pend[wa0] = 0; end
            if (we1 && wa1 != 0) begin mem[wa1] = wd1; pend[wa1] = 0; end
            if (iss_valid && iss_idx != 0) pend[iss_idx] = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; we0 = 1; wa0 = 5'd3; wd0 = $urandom; iss_valid = 1; iss_idx = 5'd4;
        tick(); tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_idx[0] = 5'(i); rd_idx[1] = 5'(31 - i); dbg_idx = 5'(i);
            #1;
            n_cmp++; if (rd_data[0] !== 32'd0) begin n_bad++; $display("FAIL reset_rd0 idx=%0d got=%h want=0", i, rd_data[0]); end
            n_cmp++; if (rd_data[1] !== 32'd0) begin n_bad++; $display("FAIL reset_rd1 idx=%0d got=%h want=0", 31-i, rd_data[1]); end
            n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL reset_busy idx=%0d got=%b want=00", i, rd_busy); end
            n_cmp++; if (dbg_data !== 32'd0) begin n_bad++; $display("FAIL reset_dbg idx=%0d got=%h want=0", i, dbg_data); end
        end
        n_cmp++; if (pend_count !== 6'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", pend_count); end
    endtask

    task automatic test_dual_write();
        logic [31:0] want;
        idle();
        we0 = 1; wa0 = REG_V0; wd0 = 32'hDEADBEEF;
        we1 = 1; wa1 = REG_V0; wd1 = 32'h12345678;
        rd_idx[0] = REG_V0;
        #1;
        want = exp_rd(REG_V0);
        n_cmp++; if (rd_data[0] !== want) begin n_bad++; $display("FAIL dual_same_cycle got=%h want=%h", rd_data[0], want); end
        tick();
        idle();
        rd_idx[1] = REG_V0; dbg_idx = REG_V0;
        #1;
        n_cmp++; if (rd_data[1] !== 32'h12345678) begin n_bad++; $display("FAIL dual_port1_wins got=%h want=12345678", rd_data[1]); end
        n_cmp++; if (dbg_data !== 32'h12345678) begin n_bad++; $display("FAIL dual_dbg got=%h want=12345678", dbg_data); end
    endtask

    task automatic test_zero_reg();
        idle();
        we0 = 1; wa0 = REG_ZERO; wd0 = 32'hFFFFFFFF;
        we1 = 1; wa1 = REG_ZERO; wd1 = 32'hFFFFFFFF;
        iss_valid = 1; iss_idx = REG_ZERO;
        tick();
        idle();
        rd_idx[0] = REG_ZERO; rd_idx[1] = REG_ZERO; dbg_idx = REG_ZERO;
        #1;
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL zero_rd got=%h want=0", rd_data); end
        n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("FAIL zero_busy got=%b want=00", rd_busy); end
        n_cmp++; if (pend_count !== 6'd0) begin n_bad++; $display("FAIL zero_count got=%0d want=0", pend_count); end
        n_cmp++; if (dbg_data !== 32'd0) begin n_bad++; $display("FAIL zero_dbg got=%h want=0", dbg_data); end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1; iss_idx = 5'd5; tick();
        iss_idx = 5'd7; tick();
        idle(); #1;
        n_cmp++; if (pend_count !== 6'd2) begin n_bad++; $display("FAIL sb_count2 got=%0d want=2", pend_count); end
        we1 = 1; wa1 = 5'd5; wd1 = 32'h55; tick();
        idle();
        rd_idx[0] = 5'd7; rd_idx[1] = 5'd5; #1;
        n_cmp++; if (pend_count !== 6'd1) begin n_bad++; $display("FAIL sb_count1 got=%0d want=1", pend_count); end
        n_cmp++; if (rd_busy !== 2'b01) begin n_bad++; $display("FAIL sb_busy_7_5 got=%b want=01", rd_busy); end
        iss_valid = 1; iss_idx = 5'd7; we0 = 1; wa0 = 5'd7; wd0 = 32'h77; tick();
        idle(); #1;
        n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sb_issue_wins got=%b want=1", rd_busy[0]); end
        n_cmp++; if (rd_data[0] !== 32'h77) begin n_bad++; $display("FAIL sb_issue_data got=%h want=77", rd_data[0]); end
        iss_valid = 1; iss_idx = 5'd7; tick();
        idle(); #1;
        n_cmp++; if (pend_count !== 6'd1) begin n_bad++; $display("FAIL sb_no_double got=%0d want=1", pend_count); end
        we0 = 1; wa0 = 5'd7; wd0 = 32'h70; tick();
        idle(); #1;
        n_cmp++; if (pend_count !== 6'd0) begin n_bad++; $display("FAIL sb_drain got=%0d want=0", pend_count); end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        idle();
        we0 = 1; wa0 = 5'd9; wd0 = 32'h11111111; tick();
        we0 = 1; wa0 = 5'd9; wd0 = 32'hA5A5A5A5; rd_idx[0] = 5'd9;
        #1;
`ifdef MIPS_REGFILE_BYPASS_EN
        want = 32'hA5A5A5A5;
`else
        want = 32'h11111111;
`endif
        n_cmp++; if (rd_data[0] !== want) begin n_bad++; $display("FAIL bypass_same_cycle got=%h want=%h", rd_data[0], want); end
        tick();
        idle(); #1;
        n_cmp++; if (rd_data[0] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL bypass_next_cycle got=%h want=a5a5a5a5", rd_data[0]); end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int k = 1; k < 32; k += 2) begin
            we0 = 1; wa0 = 5'(k); wd0 = $urandom;
            we1 = (k + 1 < 32); wa1 = 5'(k + 1); wd1 = $urandom;
            tick();
        end
        idle();
        iss_valid = 1; iss_idx = 5'd3;  tick();
        iss_idx = 5'd10; tick();
        iss_idx = 5'd20; tick();
        idle(); rd_idx[0] = 5'd17; #1;
        n_cmp++; if (pend_count !== 6'd3) begin n_bad++; $display("FAIL mid_count3 got=%0d want=3", pend_count); end
        n_cmp++; if (rd_data[0] !== mem[17]) begin n_bad++; $display("FAIL mid_load17 got=%h want=%h", rd_data[0], mem[17]); end
        reset = 1; we0 = 1; wa0 = 5'd4; wd0 = 32'hCAFEF00D; iss_valid = 1; iss_idx = 5'd6;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_idx[0] = 5'(i); rd_idx[1] = 5'(i ^ 31); #1;
            n_cmp++; if (rd_data !== '0 || rd_busy !== 2'b00) begin
                n_bad++; $display("FAIL mid_reset_rd idx=%0d got=%h/%b want=0/00", i, rd_data, rd_busy);
            end
        end
        n_cmp++; if (pend_count !== 6'd0) begin n_bad++; $display("FAIL mid_reset_count got=%0d want=0", pend_count); end
    endtask

    task automatic test_random();
        logic [31:0] wr;
        logic        wb;
        idle();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            we0       = $urandom_range(0, 1) == 1;
            we1       = $urandom_range(0, 2) == 0;
            wa0       = 5'($urandom_range(0, 31));
            wa1       = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0       = $urandom;
            wd1       = $urandom;
            iss_valid = $urandom_range(0, 2) == 0;
            iss_idx   = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            rd_idx[0] = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
            rd_idx[1] = ($urandom_range(0, 2) == 0) ? iss_idx : 5'($urandom_range(0, 31));
            dbg_idx   = 5'($urandom_range(0, 31));
            #1;
            for (int p = 0; p < NR; p++) begin
                wr = exp_rd(rd_idx[p]);
                wb = exp_busy(rd_idx[p]);
                n_cmp++; if (rd_data[p] !== wr) begin n_bad++; $display("FAIL rnd_rd cyc=%0d port=%0d idx=%0d got=%h want=%h", c, p, rd_idx[p], rd_data[p], wr); end
                n_cmp++; if (rd_busy[p] !== wb) begin n_bad++; $display("FAIL rnd_busy cyc=%0d port=%0d idx=%0d got=%b want=%b", c, p, rd_idx[p], rd_busy[p], wb); end
            end
            wr = (dbg_idx == 0) ? 32'd0 : mem[dbg_idx];
            n_cmp++; if (dbg_data !== wr) begin n_bad++; $display("FAIL rnd_dbg cyc=%0d idx=%0d got=%h want=%h", c, dbg_idx, dbg_data, wr); end
            n_cmp++; if (int'(pend_count) != exp_count()) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, pend_count, exp_count()); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rd_idx = '0; dbg_idx = '0;
        for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
